// File: rtl/ex_comp_buffer.sv
// Execute-stage completion buffer. Every cycle it takes up to M functional-unit
// results and presents up to N completions to the complete stage. Results that
// do not fit in this cycle's N slots wait in a circular FIFO. Order is strict:
// older FIFO entries go first, then new results in ascending port order.
// Slot payload packing, MSB first:
//   {rob_idx, mispredict, branch_valid, branch_taken, branch_target[31:0]}

`ifndef N
`define N 2
`endif

module ex_comp_buffer #(
    parameter int unsigned N         = `N,
    parameter int unsigned M         = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ROB_IDX_W = 5
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               squash,
    input  logic [M-1:0]                       fu_valid,
    input  logic [M-1:0][ROB_IDX_W-1:0]        fu_rob_idx,
    input  logic [M-1:0]                       fu_mispredict,
    input  logic [M-1:0]                       fu_branch_valid,
    input  logic [M-1:0]                       fu_branch_taken,
    input  logic [M-1:0][31:0]                 fu_branch_target,
    output logic [M-1:0]                       fu_ready,
    output logic [N-1:0]                       ex_valid_out,
    output logic [N-1:0][ROB_IDX_W+34:0]       ex_comp_out,
    output logic [$clog2(DEPTH):0]             count
);

    localparam int unsigned PW    = ROB_IDX_W + 35;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int          NI    = int'(N);

    logic [PW-1:0]           mem [DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;

    logic                    ready;
    logic [M-1:0]            accept;
    logic [M-1:0][PW-1:0]    fu_pkt;
    logic [N-1:0]            slot_valid;
    logic [N-1:0][PW-1:0]    slot_data;
    logic [M-1:0]            wr_en;
    logic [M-1:0][PTR_W-1:0] wr_addr;
    int                      n_pop;
    int                      n_wr;
    int                      k;

    // Room for a full M-wide burst is judged from the registered count only, so
    // fu_ready never depends combinationally on fu_valid.
    assign ready    = (32'(count) + M) <= DEPTH;
    assign fu_ready = {M{ready}};

    // Results are taken only when ready, and not while the pipe is being
    // flushed or held in reset.
    assign accept = fu_valid & fu_ready & {M{reset & ~squash}};

    // Pack each FU result into a slot payload.
    always_comb begin
        for (int i = 0; i < int'(M); i++) begin
            fu_pkt[i] = {fu_rob_idx[i], fu_mispredict[i], fu_branch_valid[i],
                         fu_branch_taken[i], fu_branch_target[i]};
        end
    end

    // Walk the stream (FIFO oldest-first, then accepted ports): the first N
    // elements fill the output slots, the rest are appended at the tail.
    always_comb begin
        slot_valid = '0;
        slot_data  = '0;
        wr_en      = '0;
        wr_addr    = '0;
        n_pop      = (int'(count) >= NI) ? NI : int'(count);
        n_wr       = 0;
        k          = n_pop;
        for (int s = 0; s < NI; s++) begin
            if (s < n_pop) begin
                slot_valid[s] = 1'b1;
                slot_data[s]  = mem[head + PTR_W'(s)];
            end
        end
        for (int i = 0; i < int'(M); i++) begin
            if (accept[i]) begin
                if (k < NI) begin
                    slot_valid[k] = 1'b1;
                    slot_data[k]  = fu_pkt[i];
                end else begin
                    wr_en[i]   = 1'b1;
                    wr_addr[i] = tail + PTR_W'(n_wr);
                    n_wr       = n_wr + 1;
                end
                k = k + 1;
            end
        end
    end

    // FIFO storage; contents are left alone on reset because count gates them.
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(M); i++) begin
            if (wr_en[i]) begin
                mem[wr_addr[i]] <= fu_pkt[i];
            end
        end
    end

    // Pointers, occupancy and the registered completion slots.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ex_valid_out <= '0;
            ex_comp_out  <= '0;
        end else if (squash) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ex_valid_out <= '0;
            ex_comp_out  <= '0;
        end else begin
            head         <= head + PTR_W'(n_pop);
            tail         <= tail + PTR_W'(n_wr);
            count        <= count + CNT_W'(n_wr) - CNT_W'(n_pop);
            ex_valid_out <= slot_valid;
            ex_comp_out  <= slot_data;
        end
    end

endmodule

// File: tb/tb_ex_comp_buffer.sv
// Scoreboard bench for ex_comp_buffer (N=2, M=4, DEPTH=8). The driver keeps a
// plain queue of waiting results, forms each cycle's stream from it and pushes
// the expected output beat; a negedge monitor pops and compares beats.

module tb_ex_comp_buffer;

    localparam int N     = 2;
    localparam int M     = 4;
    localparam int DEPTH = 8;
    localparam int RW    = 5;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic          mp;
        logic          bv;
        logic          bt;
        logic [31:0]   tgt;
    } pkt_t;

    typedef struct packed {
        logic [31:0]       tag;
        logic [N-1:0]      valid;
        pkt_t [N-1:0]      p;
        logic [3:0]        cnt;
    } beat_t;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    squash;
    logic [M-1:0]            fu_valid;
    logic [M-1:0][RW-1:0]    fu_rob_idx;
    logic [M-1:0]            fu_mispredict;
    logic [M-1:0]            fu_branch_valid;
    logic [M-1:0]            fu_branch_taken;
    logic [M-1:0][31:0]      fu_branch_target;
    logic [M-1:0]            fu_ready;
    logic [N-1:0]            ex_valid_out;
    logic [N-1:0][RW+34:0]   ex_comp_out;
    logic [3:0]              count;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    pkt_t  model_q[$];
    beat_t exp_q[$];

    ex_comp_buffer #(
        .N(N), .M(M), .DEPTH(DEPTH), .ROB_IDX_W(RW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .squash           (squash),
        .fu_valid         (fu_valid),
        .fu_rob_idx       (fu_rob_idx),
        .fu_mispredict    (fu_mispredict),
        .fu_branch_valid  (fu_branch_valid),
        .fu_branch_taken  (fu_branch_taken),
        .fu_branch_target (fu_branch_target),
        .fu_ready         (fu_ready),
        .ex_valid_out     (ex_valid_out),
        .ex_comp_out      (ex_comp_out),
        .count            (count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [19:0] mk(input int r0, input int r1, input int r2, input int r3);
        return {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
    endfunction

    // Drive one cycle of stimulus and push the beat the DUT must show next cycle.
    task automatic issue(input bit rst, input bit sq, input logic [M-1:0] v,
                         input logic [19:0] robs);
        pkt_t    p[M];
        pkt_t    stream[$];
        beat_t   b;
        bit      rdy;
        logic [31:0] r;
        for (int i = 0; i < M; i++) begin
            r        = $urandom;
            p[i].rob = robs[i*RW +: RW];
            p[i].mp  = r[0];
            p[i].bv  = r[1];
            p[i].bt  = r[2];
            p[i].tgt = $urandom;
            fu_rob_idx[i]       = p[i].rob;
            fu_mispredict[i]    = p[i].mp;
            fu_branch_valid[i]  = p[i].bv;
            fu_branch_taken[i]  = p[i].bt;
            fu_branch_target[i] = p[i].tgt;
        end
        reset    = rst;
        squash   = sq;
        fu_valid = v;
        rdy = (DEPTH - model_q.size()) >= M;
        #1;
        checks++;
        if (fu_ready !== {M{rdy}}) begin
            errors++;
            $display("FAIL fu_ready cyc=%0d actual=%b required=%b", cyc, fu_ready, {M{rdy}});
        end
        b     = '0;
        b.tag = 32'(cyc + 1);
        if (!rst || sq) begin
            model_q.delete();
        end else begin
            stream = model_q;
            if (rdy) begin
                for (int i = 0; i < M; i++) if (v[i]) stream.push_back(p[i]);
            end
            for (int s = 0; s < N; s++) begin
                if (stream.size() > 0) begin
                    b.valid[s] = 1'b1;
                    b.p[s]     = stream.pop_front();
                end
            end
            model_q = stream;
        end
        b.cnt = 4'(model_q.size());
        exp_q.push_back(b);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 1'b0, '0, 20'h0);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest due beat.
    always @(negedge clock) begin
        beat_t b;
        if (exp_q.size() > 0 && int'(exp_q[0].tag) == cyc) begin
            b = exp_q.pop_front();
            checks++;
            if (ex_valid_out !== b.valid) begin
                errors++;
                $display("FAIL ex_valid_out cyc=%0d actual=%b required=%b",
                         cyc, ex_valid_out, b.valid);
            end
            for (int s = 0; s < N; s++) begin
                checks++;
                if (ex_comp_out[s] !== b.p[s]) begin
                    errors++;
                    $display("FAIL slot%0d cyc=%0d actual=%h required=%h",
                             s, cyc, ex_comp_out[s], b.p[s]);
                end
            end
            checks++;
            if (count !== b.cnt) begin
                errors++;
                $display("FAIL count cyc=%0d actual=%0d required=%0d", cyc, count, b.cnt);
            end
        end else if (exp_q.size() > 0 && int'(exp_q[0].tag) < cyc) begin
            b = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL beat_missed cyc=%0d actual=none required=tag%0d", cyc, b.tag);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [M-1:0] v;
        int           r;
        reset            = 1'b0;
        squash           = 1'b0;
        fu_valid         = '0;
        fu_rob_idx       = '0;
        fu_mispredict    = '0;
        fu_branch_valid  = '0;
        fu_branch_taken  = '0;
        fu_branch_target = '0;
        repeat (2) @(posedge clock);
        #1;

        // Single result on an empty buffer.
        issue(1'b1, 1'b0, 4'b0100, mk(0, 0, 5, 0));
        idle(2);
        // Four results: two out now, two the cycle after.
        issue(1'b1, 1'b0, 4'b1111, mk(1, 2, 3, 4));
        idle(3);
        // Sustained bursts drive count up until fu_ready drops.
        for (int c = 0; c < 6; c++) issue(1'b1, 1'b0, 4'b1111, mk(6 + 4*c, 7 + 4*c, 8 + 4*c, 9 + 4*c));
        idle(6);
        // Squash with count=5 and three ports valid.
        issue(1'b1, 1'b0, 4'b1111, mk(10, 11, 12, 13));
        issue(1'b1, 1'b0, 4'b1111, mk(14, 15, 16, 17));
        issue(1'b1, 1'b0, 4'b0111, mk(18, 19, 20, 0));
        issue(1'b1, 1'b1, 4'b0111, mk(21, 22, 23, 0));
        idle(3);
        // Mid-operation reset with count=6, then a lone accept.
        for (int c = 0; c < 3; c++) issue(1'b1, 1'b0, 4'b1111, mk(24, 25, 26, 27));
        issue(1'b0, 1'b0, 4'b1111, mk(28, 29, 30, 31));
        issue(1'b1, 1'b0, 4'b0001, mk(9, 0, 0, 0));
        idle(3);
        // Randomized traffic; long bursts wrap the pointers many times.
        for (int c = 0; c < 600; c++) begin
            r = int'($urandom_range(0, 99));
            v = 4'($urandom);
            if (r < 2)       issue(1'b0, 1'b0, v, 20'($urandom));
            else if (r < 5)  issue(1'b1, 1'b1, v, 20'($urandom));
            else if (r < 20) issue(1'b1, 1'b0, '0, 20'($urandom));
            else             issue(1'b1, 1'b0, v, 20'($urandom));
        end
        idle(8);
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_comp_buffer.md
EX_COMP_BUFFER -- requirements
Module: ex_comp_buffer

Interface
REQ-001 SHALL have parameter N, default `N; completion slots per cycle toward stage_complete.
REQ-002 SHALL have parameter M, default 4; functional-unit result ports.
REQ-003 SHALL have parameter DEPTH, default 8; FIFO entries, power of 2, DEPTH >= M.
REQ-004 SHALL have parameter ROB_IDX_W, default 5; ROB index width.
REQ-005 SHALL have ports: clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have ports: reset  in  1  synchronous, active-low (0 = reset).
REQ-007 SHALL have ports: squash  in  1  pipeline flush, synchronous, active-high.
REQ-008 SHALL have ports: fu_valid  in  M  FU result present.
REQ-009 SHALL have ports: fu_rob_idx  in  M x ROB_IDX_W; fu_mispredict  in  M; fu_branch_valid  in  M; fu_branch_taken  in  M; fu_branch_target  in  M x 32.
REQ-010 SHALL have ports: fu_ready  out  M  result accepted this cycle when fu_valid & fu_ready.
REQ-011 SHALL have ports: ex_valid_out  out  N; ex_comp_out  out  EX_COMPLETE_PACKET (rob_idx, mispredict, branch_valid, branch_taken, branch_target per slot).
REQ-012 SHALL have ports: count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL hold results in a circular FIFO (head, tail pointers wrapping modulo DEPTH, plus count).
REQ-014 SHALL drive all M bits of fu_ready identically: 1 iff DEPTH - count >= M, else 0; computed from registered count only.
REQ-015 SHALL form each cycle an ordered stream: FIFO entries oldest-first, then accepted fu results in ascending port index.
REQ-016 SHALL register the first min(N, stream length) stream elements into ex_valid_out/ex_comp_out slots 0.. in order; unused slots valid=0, payload 0.
REQ-017 SHALL write stream elements beyond the first N into the FIFO at tail in stream order (the FIFO part of the stream is popped from head first).
REQ-018 SHALL yield latency exactly 1 cycle from acceptance to ex_valid_out when FIFO holds fewer than N entries before acceptance.
REQ-019 SHALL update count as count + accepted - popped, with popped = min(N, count).
REQ-020 SHALL never overflow; an accept with fu_ready=0 is ignored (fu_valid without fu_ready drops nothing, FU must hold).
REQ-021 SHALL preserve total order: no result leaves before any result accepted earlier or at a lower port in the same cycle.
REQ-022 SHALL copy branch_taken/branch_target unchanged regardless of branch_valid.
REQ-023 SHALL on squash=1: next cycle count=0, head=tail=0, ex_valid_out=0; inputs that cycle discarded.
REQ-024 SHALL give reset priority over squash.
REQ-025 SHALL handle pointer wrap DEPTH-1 -> 0 without loss or duplication.

Reset
REQ-026 SHALL, while reset=0 at a rising edge, set count=0, head=tail=0, ex_valid_out=0, ex_comp_out=0.
REQ-027 SHALL drive fu_ready all-ones in the cycle after reset deasserts.
REQ-028 SHALL discard FIFO contents when reset is asserted mid-operation; no stale entry emitted afterwards.

Verification (N=2, M=4, DEPTH=8)
REQ-029 SHALL cover: single fu_valid[2], rob_idx=5 on empty buffer -> next cycle ex_valid_out=2'b01, slot0 rob_idx=5, count=0.
REQ-030 SHALL cover: all 4 ports valid, rob_idx 1,2,3,4, empty buffer -> next cycle slots = 1,2, count=2; following cycle slots = 3,4, count=0.
REQ-031 SHALL cover: 4 results/cycle for 3 cycles -> count 2,4,6; fu_ready drops to 0 at count=6 (8-6<4) and returns when count<=4.
REQ-032 SHALL cover: fill with head near 7 so tail wraps -> emitted rob_idx order matches acceptance order, no gaps or duplicates.
REQ-033 SHALL cover: squash with count=5 and 3 ports valid -> next cycle count=0, ex_valid_out=0, none of those 8 results ever emitted.
REQ-034 SHALL cover: reset=0 held 1 cycle with count=6 -> count=0, outputs zero; first post-reset accept rob_idx=9 emitted alone 1 cycle later.
